press_repeat_counter: RTL and testbench

- Sits directly downstream of the button debounce/edge stage; consumes debounced levels and rising-edge pulses for an "up" and a "down" button plus a clear pulse.
- Maintains a WIDTH-bit count that drives the board LEDs.
- Single press steps by one; holding a button past a hold delay auto-repeats at a fixed rate.
- Configurable wrap-around or saturation at the count limits.

---
 rtl/press_repeat_counter.sv | 126 ++++++++++++
 tb/tb_press_repeat_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/press_repeat_counter.sv
// Up/down press counter with hold-to-repeat, fed by debounced button levels and edge pulses.
// A press steps once; holding past HOLD_CYCLES auto-repeats every REPEAT_CYCLES.
module press_repeat_counter #(
  parameter int WIDTH         = 16,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int WRAP          = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             up_level,
  input  logic             up_pulse,
  input  logic             down_level,
  input  logic             down_pulse,
  input  logic             clear_pulse,
  output logic [WIDTH-1:0] count,
  output logic             changed,
  output logic             wrap,
  output logic             repeat_active
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    RPT_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, HOLD_UP, RPT_UP, HOLD_DN, RPT_DN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          step_up, step_dn;

  // Next-state decision; clear and a double press both abandon any step.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    if (clear_pulse || (up_pulse && down_pulse)) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_nxt = '0;
          if (up_pulse && !down_level) begin
            step_up   = 1'b1;
            state_nxt = HOLD_UP;
          end else if (down_pulse && !up_level) begin
            step_dn   = 1'b1;
            state_nxt = HOLD_DN;
          end
        end
        HOLD_UP, RPT_UP: begin
          if (!up_level || down_level) begin
            state_nxt = IDLE;
            timer_nxt = '0;
          end else if (timer == ((state == HOLD_UP) ? HOLD_LAST : RPT_LAST)) begin
            step_up   = 1'b1;
            state_nxt = RPT_UP;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        HOLD_DN, RPT_DN: begin
          if (!down_level || up_level) begin
            state_nxt = IDLE;
            timer_nxt = '0;
          end else if (timer == ((state == HOLD_DN) ? HOLD_LAST : RPT_LAST)) begin
            step_dn   = 1'b1;
            state_nxt = RPT_DN;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      count         <= '0;
      changed       <= 1'b0;
      wrap          <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      repeat_active <= (state_nxt == RPT_UP) || (state_nxt == RPT_DN);
      changed       <= 1'b0;
      wrap          <= 1'b0;
      if (clear_pulse) begin
        count   <= '0;
        changed <= |count;
      end else if (step_up) begin
        if (count != CNT_MAX) begin
          count   <= count + 1'b1;
          changed <= 1'b1;
        end else if (WRAP != 0) begin
          count   <= '0;
          changed <= 1'b1;
          wrap    <= 1'b1;
        end
      end else if (step_dn) begin
        if (count != '0) begin
          count   <= count - 1'b1;
          changed <= 1'b1;
        end else if (WRAP != 0) begin
          count   <= CNT_MAX;
          changed <= 1'b1;
          wrap    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_press_repeat_counter.sv
// Drives a wrapping and a saturating instance with shared stimulus and checks both
// against a press-age model: a step fires at age 0, HOLD, HOLD+REPEAT, ...
module tb_press_repeat_counter;
  localparam int W = 4, H = 8, R = 4, MAXV = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic up_level = 0, up_pulse = 0, down_level = 0, down_pulse = 0, clear_pulse = 0;
  logic [1:0][W-1:0] d_cnt;
  logic [1:0]        d_chg, d_wrp, d_rpt;

  always #5 clk = ~clk;

  press_repeat_counter #(.WIDTH(W), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .up_level(up_level), .up_pulse(up_pulse),
    .down_level(down_level), .down_pulse(down_pulse), .clear_pulse(clear_pulse),
    .count(d_cnt[0]), .changed(d_chg[0]), .wrap(d_wrp[0]), .repeat_active(d_rpt[0]));

  press_repeat_counter #(.WIDTH(W), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .up_level(up_level), .up_pulse(up_pulse),
    .down_level(down_level), .down_pulse(down_pulse), .clear_pulse(clear_pulse),
    .count(d_cnt[1]), .changed(d_chg[1]), .wrap(d_wrp[1]), .repeat_active(d_rpt[1]));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %0d want %0d at %0t", name, k, got, want, $time);
    end
  endtask

  // Model: mode 0 none, 1 up held, 2 down held; age = cycles since the press step.
  int m_cnt [2];
  bit m_chg [2], m_wrp [2];
  bit m_rpt;
  int mode, age;

  initial begin
    m_cnt = '{0, 0}; m_chg = '{0, 0}; m_wrp = '{0, 0}; m_rpt = 0; mode = 0; age = 0;
  end

  function automatic void step(input int dir);
    for (int k = 0; k < 2; k++) begin
      if (dir > 0) begin
        if (m_cnt[k] < MAXV) begin m_cnt[k]++; m_chg[k] = 1; end
        else if (k == 0) begin m_cnt[k] = 0; m_chg[k] = 1; m_wrp[k] = 1; end
      end else begin
        if (m_cnt[k] > 0) begin m_cnt[k]--; m_chg[k] = 1; end
        else if (k == 0) begin m_cnt[k] = MAXV; m_chg[k] = 1; m_wrp[k] = 1; end
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = '{0, 0}; m_chg = '{0, 0}; m_wrp = '{0, 0}; m_rpt = 0; mode = 0; age = 0;
    end else begin
      m_chg = '{0, 0}; m_wrp = '{0, 0};
      if (clear_pulse) begin
        for (int k = 0; k < 2; k++) begin
          m_chg[k] = (m_cnt[k] != 0);
          m_cnt[k] = 0;
        end
        mode = 0; age = 0;
      end else if (up_pulse && down_pulse) begin
        mode = 0; age = 0;
      end else if (mode == 0) begin
        if (up_pulse && !down_level) begin step(1); mode = 1; age = 0; end
        else if (down_pulse && !up_level) begin step(-1); mode = 2; age = 0; end
      end else if ((mode == 1 && (!up_level || down_level)) ||
                   (mode == 2 && (!down_level || up_level))) begin
        mode = 0; age = 0;
      end else begin
        age++;
        if (age >= H && (age - H) % R == 0) step(mode == 1 ? 1 : -1);
      end
      m_rpt = (mode != 0) && (age >= H);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("count", k, 32'(d_cnt[k]), 32'(m_cnt[k]));
      chk("changed", k, 32'(d_chg[k]), 32'(m_chg[k]));
      chk("wrap", k, 32'(d_wrp[k]), 32'(m_wrp[k]));
      chk("repeat_active", k, 32'(d_rpt[k]), 32'(m_rpt));
    end
  end

  task automatic drive(input logic ul, input logic up, input logic dl, input logic dp, input logic cl);
    up_level = ul; up_pulse = up; down_level = dl; down_pulse = dp; clear_pulse = cl;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int c0, input int c1);
    chk({name, "_count"}, 0, 32'(d_cnt[0]), 32'(c0));
    chk({name, "_count"}, 1, 32'(d_cnt[1]), 32'(c1));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 0, 0);
    chk("reset_rpt", 0, 32'(d_rpt[0]), 0);
    chk("reset_chg", 0, 32'(d_chg[0]), 0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // single tap
    drive(1, 1, 0, 0, 0);
    lit("tap", 1, 1);
    chk("tap_chg", 0, 32'(d_chg[0]), 1);
    drive(1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
    lit("tap_end", 1, 1);
    chk("tap_rpt", 0, 32'(d_rpt[0]), 0);
    drive(0, 0, 0, 0, 1);
    lit("clear", 0, 0);

    // hold 20 cycles: steps after edges 1, 9, 13, 17
    drive(1, 1, 0, 0, 0);
    repeat (7) drive(1, 0, 0, 0, 0);
    lit("hold8", 1, 1);
    chk("hold8_rpt", 0, 32'(d_rpt[0]), 0);
    drive(1, 0, 0, 0, 0);
    lit("hold9", 2, 2);
    chk("hold9_rpt", 0, 32'(d_rpt[0]), 1);
    repeat (11) drive(1, 0, 0, 0, 0);
    lit("hold20", 4, 4);
    drive(0, 0, 0, 0, 0);
    chk("release_rpt", 0, 32'(d_rpt[0]), 0);

    // wrap / saturate at zero
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 0);
    lit("dn_at0", 15, 0);
    chk("dn_wrap", 0, 32'(d_wrp[0]), 1);
    chk("dn_wrap", 1, 32'(d_wrp[1]), 0);
    chk("dn_chg_sat", 1, 32'(d_chg[1]), 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    lit("up_at15", 0, 1);
    chk("up_wrap", 0, 32'(d_wrp[0]), 1);
    drive(0, 0, 0, 0, 0);

    // long hold: 19 steps, saturating instance pins at 15
    drive(1, 1, 0, 0, 0);
    repeat (79) drive(1, 0, 0, 0, 0);
    lit("long", 3, 15);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (19) drive(1, 0, 0, 0, 0);
    lit("sat_hold", 7, 15);
    drive(0, 0, 0, 0, 0);

    // simultaneous presses
    drive(1, 1, 1, 1, 0);
    lit("both", 7, 15);
    drive(0, 0, 0, 0, 0);

    // opposite level during repeat stops it
    drive(1, 1, 0, 0, 0);
    repeat (9) drive(1, 0, 0, 0, 0);
    lit("rpt_up", 9, 15);
    chk("rpt_up_rpt", 0, 32'(d_rpt[0]), 1);
    drive(1, 0, 1, 1, 0);
    chk("opp_rpt", 0, 32'(d_rpt[0]), 0);
    repeat (10) drive(1, 0, 1, 0, 0);
    lit("opp_hold", 9, 15);
    drive(0, 0, 0, 0, 0);

    // clear on the same cycle as the first repeat step
    drive(1, 1, 0, 0, 0);
    repeat (7) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    lit("clr_step", 0, 0);
    chk("clr_chg", 1, 32'(d_chg[1]), 1);
    repeat (10) drive(1, 0, 0, 0, 0);
    lit("clr_after", 0, 0);
    drive(0, 0, 0, 0, 0);

    // async reset mid repeat-down
    drive(0, 0, 1, 1, 0);
    repeat (9) drive(0, 0, 1, 0, 0);
    lit("rpt_dn", 14, 0);
    chk("rpt_dn_rpt", 0, 32'(d_rpt[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    lit("async_rst", 0, 0);
    chk("async_rpt", 0, 32'(d_rpt[0]), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) drive(0, 0, 1, 0, 0);
    lit("post_rst", 0, 0);
    drive(0, 0, 0, 0, 0);

    // random: levels with occasional toggles, pulses on rising edges
    for (int i = 0; i < 3000; i++) begin
      logic ul, dl, cl;
      ul = ($urandom_range(15) == 0) ? !up_level : up_level;
      dl = ($urandom_range(23) == 0) ? !down_level : down_level;
      cl = ($urandom_range(59) == 0);
      drive(ul, ul & !up_level, dl, dl & !down_level, cl);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
